cnt_rr_sched: RTL and testbench
===============================

# cnt_rr_sched

Round-robin scheduler that shares one `svproj1_cnt` counter among `N_REQ` requesters. Each requester posts a count length. The scheduler grants one requester at a time, issues a one-cycle run pulse with that length to the counter, waits for the counter's done, and returns a one-cycle done pulse to the owning requester. It sits between the requester blocks and the single counter instance, which shares `clk` and `reset_n` with it.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATABIT`, 7: count-length width; must match the counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_req` in N_REQ: level request per requester; held until that requester's `o_done` is seen.
- `i_num_cnt` in N_REQ*DATABIT: packed lengths; slice k = bits [k*DATABIT +: DATABIT].
- `o_grant` out N_REQ: one-hot owner of the counter, else 0.
- `o_done` out N_REQ: one-cycle completion pulse to the owner.
- `o_busy` out 1: high whenever the FSM is not in S_IDLE.
- `o_cnt_run` out 1: run pulse to the counter `i_run`.
- `o_cnt_num` out DATABIT: length to the counter `i_num_cnt`.
- `i_cnt_idle` in 1: from the counter `o_idle`.
- `i_cnt_done` in 1: from the counter `o_done`, a one-cycle pulse.

## Operation
- FSM states: S_IDLE, S_ISSUE, S_RUN, S_DONE.
- **S_IDLE:**
  - If any `i_req` is high and `i_cnt_idle`=1, pick the winner by round-robin. The search starts at index `last+1` and wraps modulo N_REQ.
  - Latch the winner index into `sel` and its length into `num_q`.
  - If `num_q`!=0, go to S_ISSUE. If `num_q`==0, go to S_DONE and never touch the counter.
  - If `i_cnt_idle`=0, hold in S_IDLE.
- **S_ISSUE:** `o_cnt_run`=1 and `o_cnt_num`=`num_q` for exactly this cycle, then go to S_RUN.
- **S_RUN:** wait for `i_cnt_done`=1, then go to S_DONE. There is no timeout.
- **S_DONE:** `o_done[sel]`=1 for this cycle, `last`<=`sel`, then go to S_IDLE.
- `o_grant[sel]`=1 from S_ISSUE through S_DONE inclusive. For a zero-length job, `o_grant` is high during S_DONE only.
- The length is sampled only at grant. Later changes to `i_num_cnt` are ignored.
- A request dropped while granted does not abort the job. The job completes and `o_done` still pulses.
- `i_cnt_done` outside S_RUN is ignored.
- `o_cnt_num` holds its last value when not in S_ISSUE.
- All outputs are registered.

## Timing
- Reset values:
  - State S_IDLE.
  - `o_grant`=0, `o_done`=0, `o_busy`=0, `o_cnt_run`=0, `o_cnt_num`=0.
  - `last`=N_REQ-1, so index 0 has first priority.
- Requests are sampled at edge E in S_IDLE.
  - `o_cnt_run` and `o_grant` are high in the cycle after E.
- `i_cnt_done` is sampled at edge F.
  - `o_done` is high in the cycle after F, and S_IDLE follows one cycle later.
- Handshake: the requester deasserts `i_req` at the edge where it samples `o_done`=1. It is therefore low in the following S_IDLE cycle.
- Minimum turnaround, from `o_done` to the next `o_cnt_run`, is 2 cycles.
- Simultaneous requests: only one winner per arbitration. The just-served index has lowest priority on the next pick.
- `reset_n` low at any time (mid-run included) forces all reset values asynchronously. The in-flight job is dropped with no `o_done`.

## Structure
- Package `cnt_rr_sched_pkg` holds:
  - The state enum (S_IDLE, S_ISSUE, S_RUN, S_DONE).
  - Default `DATABIT`=7 and `N_REQ`=4 constants.
- Sub-module `rr_pick`: a combinational round-robin priority encoder.
  - Inputs: `req` and `last`.
  - Outputs: `valid` and `idx`.
- The FSM, latches and output registers stay in the top module.

## Test plan
- **Single request:** after reset, req0 with length 100.
  - `o_cnt_run` pulses once with `o_cnt_num`=100.
  - `o_grant`=4'b0001 until done.
  - `o_done[0]` pulses the cycle after the counter's `o_done`.
- **Fairness:** req0..3 all held with lengths 5, 6, 7, 8.
  - Issue order is 0,1,2,3, each with its own length.
  - Re-asserted req0 is served again only after index 3.
- **Zero length:** req2 with length 0.
  - `o_cnt_run` never asserts.
  - `o_done[2]` pulses 1 cycle after the grant decision.
- **Counter not idle:** force `i_cnt_idle`=0 with req1 pending.
  - No grant.
  - The grant follows the cycle after `i_cnt_idle` rises.
- **Length change and request drop mid-job:** req3 with length 10; mid-run change the length to 50 and drop req3.
  - The counter runs with 10.
  - `o_done[3]` still pulses.
- **Reset mid-run:** assert `reset_n`=0 during S_RUN.
  - All outputs are 0 immediately.
  - No `o_done` pulse.
  - After release, req0 is granted first.

Source files
------------

// File: rtl/cnt_rr_sched_pkg.sv
// Shared types and defaults for the round-robin counter scheduler.
package cnt_rr_sched_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DATABIT_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_rr_sched_if.sv
// Requester-side and counter-side signals of the scheduler bundled together.
interface cnt_rr_sched_if
    import cnt_rr_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATABIT = DATABIT_DEF
) ();

    logic [N_REQ-1:0]         i_req;
    logic [N_REQ*DATABIT-1:0] i_num_cnt;
    logic [N_REQ-1:0]         o_grant;
    logic [N_REQ-1:0]         o_done;
    logic                     o_busy;
    logic                     o_cnt_run;
    logic [DATABIT-1:0]       o_cnt_num;
    logic                     i_cnt_idle;
    logic                     i_cnt_done;

    // master: requesters plus the shared counter; slave: the scheduler
    modport master (
        output i_req, i_num_cnt, i_cnt_idle, i_cnt_done,
        input  o_grant, o_done, o_busy, o_cnt_run, o_cnt_num
    );

    modport slave (
        input  i_req, i_num_cnt, i_cnt_idle, i_cnt_done,
        output o_grant, o_done, o_busy, o_cnt_run, o_cnt_num
    );

endinterface

// File: rtl/cnt_rr_sched_rr_pick.sv
// Combinational round-robin priority encoder: first set request after 'last', wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // cand[k] is the index searched k-th, starting just after 'last'
    logic [IDX_W-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((32'(last) + 32'(gi) + 32'd1) % 32'(N_REQ));
        end
    endgenerate

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/cnt_rr_sched.sv
// Shares one counter among N_REQ requesters: round-robin grant, run pulse, wait done, done pulse.
module cnt_rr_sched
    import cnt_rr_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATABIT = DATABIT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    cnt_rr_sched_if.slave bus
);

    localparam int IDX_W = idx_width(N_REQ);

    state_t             state_q;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   last_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic               busy_q;
    logic               run_q;
    logic [DATABIT-1:0] num_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATABIT-1:0] pick_len;
    logic [N_REQ-1:0]   pick_onehot;
    logic [DATABIT-1:0] len_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_len
            assign len_arr[gi] = bus.i_num_cnt[gi*DATABIT +: DATABIT];
        end
    endgenerate

    assign pick_len    = len_arr[pick_idx];
    assign pick_onehot = N_REQ'(1) << pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.i_req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
            num_q   <= '0;
        end else begin
            run_q  <= 1'b0;
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid && bus.i_cnt_idle) begin
                        sel_q   <= pick_idx;
                        grant_q <= pick_onehot;
                        busy_q  <= 1'b1;
                        // num_q drives the counter length, so zero-length jobs leave it alone
                        if (pick_len != '0) begin
                            state_q <= S_ISSUE;
                            run_q   <= 1'b1;
                            num_q   <= pick_len;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= pick_onehot;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (bus.i_cnt_done) begin
                        state_q <= S_DONE;
                        done_q  <= grant_q;
                    end
                end
                S_DONE: begin
                    last_q  <= sel_q;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_done    = done_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_cnt_run = run_q;
    assign bus.o_cnt_num = num_q;

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Self-checking bench for cnt_rr_sched with a behavioural counter and a scoreboard.
module tb_cnt_rr_sched;

    localparam int N  = 4;
    localparam int DW = 7;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cnt_rr_sched_if #(.N_REQ(N), .DATABIT(DW)) bus ();

    cnt_rr_sched #(.N_REQ(N), .DATABIT(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // behavioural counter: done pulse 'len' cycles after the run pulse
    logic          running;
    logic          mdone;
    logic          stray;
    logic          force_busy;
    logic [DW-1:0] rem;
    logic [DW-1:0] model_len;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running   <= 1'b0;
            mdone     <= 1'b0;
            rem       <= '0;
            model_len <= '0;
        end else begin
            mdone <= 1'b0;
            if (bus.o_cnt_run) begin
                running   <= 1'b1;
                rem       <= bus.o_cnt_num;
                model_len <= bus.o_cnt_num;
            end else if (running) begin
                if (rem <= 1) begin
                    running <= 1'b0;
                    mdone   <= 1'b1;
                end else begin
                    rem <= rem - 1'b1;
                end
            end
        end
    end

    assign bus.i_cnt_done = mdone | stray;
    assign bus.i_cnt_idle = ~running & ~force_busy;

    typedef struct {
        logic [N-1:0]      req;
        logic [N*DW-1:0]   lens;
        int                n;
        logic [5:0][1:0]   order;
        bit                rearm;
    } vec_t;

    typedef struct {
        int idx;
        int len;
    } job_t;

    vec_t tbl [6];
    job_t issue_q [$];
    int   done_q [$];
    int   checks = 0;
    int   errors = 0;
    bit   rearm_pending = 1'b0;
    bit   rearm_now = 1'b0;

    function automatic vec_t mk(input logic [3:0] req, input int l3, input int l2, input int l1,
                                input int l0, input int n, input int o0, input int o1, input int o2,
                                input int o3, input int o4, input bit rearm);
        vec_t v;
        v.req   = req;
        v.lens  = {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
        v.n     = n;
        v.order = {2'd0, 2'(o4), 2'(o3), 2'(o2), 2'(o1), 2'(o0)};
        v.rearm = rearm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one negedge: scoreboard compare, then requester handshake
    task automatic tick();
        job_t j;
        int   k;
        @(negedge clk);
        chk("busy_vs_grant", {31'd0, bus.o_busy}, {31'd0, (bus.o_grant != '0)});
        if (bus.o_cnt_run) begin
            if (issue_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run: got num=%0d expected no run", bus.o_cnt_num);
            end else begin
                j = issue_q.pop_front();
                $display("run   idx=%0d num=%0d grant=%b", j.idx, bus.o_cnt_num, bus.o_grant);
                chk("run_num", 32'(bus.o_cnt_num), 32'(j.len));
                chk("run_grant", 32'(bus.o_grant), 32'd1 << j.idx);
            end
        end
        if (bus.o_done != '0) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got %b expected none", bus.o_done);
            end else begin
                k = done_q.pop_front();
                $display("done  idx=%0d done=%b grant=%b", k, bus.o_done, bus.o_grant);
                chk("done_onehot", 32'(bus.o_done), 32'd1 << k);
                chk("done_grant", 32'(bus.o_grant), 32'd1 << k);
            end
            if (rearm_pending && bus.o_done[0]) begin
                rearm_pending = 1'b0;
                rearm_now     = 1'b1;
            end
            bus.i_req = bus.i_req & ~bus.o_done;
        end else if (rearm_now) begin
            rearm_now    = 1'b0;
            bus.i_req[0] = 1'b1;
        end
    endtask

    task automatic drive_batch(input vec_t v);
        job_t j;
        for (int i = 0; i < v.n; i++) begin
            j.idx = int'(v.order[i]);
            j.len = int'(v.lens[j.idx*DW +: DW]);
            if (j.len != 0) issue_q.push_back(j);
            done_q.push_back(j.idx);
        end
        bus.i_num_cnt = v.lens;
        bus.i_req     = v.req;
        rearm_pending = v.rearm;
        rearm_now     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.i_req != '0 || issue_q.size() != 0 || done_q.size() != 0 || bus.o_busy)
               && n < budget) begin
            tick();
            n++;
        end
        chk("batch_within_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.o_grant), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
        chk({tag, "_run"}, {31'd0, bus.o_cnt_run}, 32'd0);
        chk({tag, "_num"}, 32'(bus.o_cnt_num), 32'd0);
    endtask

    initial begin
        bus.i_req     = '0;
        bus.i_num_cnt = '0;
        stray         = 1'b0;
        force_busy    = 1'b0;

        // req, lengths 3..0, job count, expected service order, rearm req0 after its done
        tbl[0] = mk(4'b1111, 8, 7, 6, 5,   5, 0, 1, 2, 3, 0, 1'b1);
        tbl[1] = mk(4'b0001, 0, 0, 0, 100, 1, 0, 0, 0, 0, 0, 1'b0);
        tbl[2] = mk(4'b0100, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 1'b0);
        tbl[3] = mk(4'b1010, 4, 0, 9, 0,   2, 3, 1, 0, 0, 0, 1'b0);
        tbl[4] = mk(4'b0011, 0, 0, 2, 3,   2, 0, 1, 0, 0, 0, 1'b0);
        tbl[5] = mk(4'b1111, 4, 3, 2, 1,   4, 2, 3, 0, 1, 0, 1'b0);

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        for (int t = 0; t < 6; t++) begin
            $display("vector %0d req=%b", t, tbl[t].req);
            drive_batch(tbl[t]);
            wait_idle(3000);
        end

        // zero length: done one cycle after the decision, no run pulse
        $display("seq zero_length");
        done_q.push_back(2);
        bus.i_num_cnt = '0;
        bus.i_req     = 4'b0100;
        tick();
        chk("zero_run", {31'd0, bus.o_cnt_run}, 32'd0);
        chk("zero_grant", 32'(bus.o_grant), 32'd4);
        tick();
        chk("zero_grant_after", 32'(bus.o_grant), 32'd0);
        chk("zero_busy_after", {31'd0, bus.o_busy}, 32'd0);

        // counter busy: hold off, grant the cycle after idle rises
        $display("seq cnt_not_idle");
        force_busy = 1'b1;
        drive_batch(mk(4'b0010, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 1'b0));
        repeat (4) tick();
        chk("notidle_grant", 32'(bus.o_grant), 32'd0);
        chk("notidle_busy", {31'd0, bus.o_busy}, 32'd0);
        force_busy = 1'b0;
        tick();
        chk("idle_rise_grant", 32'(bus.o_grant), 32'd2);
        chk("idle_rise_run", {31'd0, bus.o_cnt_run}, 32'd1);
        wait_idle(200);

        // length change and request drop mid-job
        $display("seq len_change_drop");
        drive_batch(mk(4'b1000, 10, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1'b0));
        tick();
        tick();
        bus.i_num_cnt = {7'd50, 7'd0, 7'd0, 7'd0};
        bus.i_req     = '0;
        tick();
        chk("num_hold", 32'(bus.o_cnt_num), 32'd10);
        chk("grant_hold", 32'(bus.o_grant), 32'd8);
        wait_idle(200);
        chk("counter_len", 32'(model_len), 32'd10);

        // stray counter done while idle is ignored
        $display("seq stray_done");
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_done", 32'(bus.o_done), 32'd0);
        chk("stray_busy", {31'd0, bus.o_busy}, 32'd0);

        // move last away from 3 so the post-reset pick proves last was reset
        drive_batch(mk(4'b0100, 0, 2, 0, 0, 1, 2, 0, 0, 0, 0, 1'b0));
        wait_idle(200);

        $display("seq reset_mid_run");
        drive_batch(mk(4'b0010, 0, 0, 40, 0, 1, 1, 0, 0, 0, 0, 1'b0));
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        bus.i_req = '0;
        done_q.delete();
        issue_q.delete();
        tick();
        chk("reset_no_done", 32'(bus.o_done), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        drive_batch(mk(4'b1111, 4, 3, 2, 1, 4, 0, 1, 2, 3, 0, 1'b0));
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
